// File: rtl/lsu_ctrl.sv
// Load/store controller: turns one CPU access into memory cycles, with read-modify-write for sub-word stores.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned halfword/word requests to ERR).
module lsu_ctrl #(
    parameter int MAX_WORD_INDEX = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mwr,
    output logic        moe,
    output logic [31:0] ma,
    output logic [31:0] mwd,
    input  logic [31:0] mrd
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

    state_t      state, state_next;
    logic        cap_we, cap_sext;
    logic [1:0]  cap_size, cap_lane;
    logic [15:0] cap_wdata;
    logic        out_of_range, misaligned;
    logic        busy_next, done_next, err_next, mwr_next, moe_next;
    logic [31:0] rdata_next, ma_next, mwd_next;

    // Replace only the addressed byte/halfword lane of the word read back from memory.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic [15:0] data);
        logic [31:0] m;
        m = word;
        case (sz)
            2'b00:   m[{lane, 3'b000} +: 8]      = data[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = data;
            default: m = word;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign out_of_range = ({2'b00, addr[31:2]} > 32'(MAX_WORD_INDEX));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        err_next   = 1'b0;
        mwr_next   = 1'b0;
        moe_next   = 1'b0;
        ma_next    = ma;
        mwd_next   = mwd;
        rdata_next = rdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (out_of_range || misaligned) begin
                        state_next = S_ERR;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else if (we && size[1]) begin
                        state_next = S_WRITE;
                        mwr_next   = 1'b1;
                        ma_next    = {addr[31:2], 2'b00};
                        mwd_next   = wdata;
                    end else begin
                        state_next = S_READ;
                        moe_next   = 1'b1;
                        ma_next    = {addr[31:2], 2'b00};
                    end
                end
            end
            S_READ: begin
                // mrd is valid this cycle; it becomes either the merged store word or the load result.
                if (cap_we) begin
                    state_next = S_WRITE;
                    mwr_next   = 1'b1;
                    mwd_next   = merge_store(mrd, cap_size, cap_lane, cap_wdata);
                end else begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    rdata_next = extract_load(mrd, cap_size, cap_lane, cap_sext);
                end
            end
            S_WRITE: begin
                state_next = S_DONE;
                done_next  = 1'b1;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            mwr   <= 1'b0;
            moe   <= 1'b0;
            ma    <= '0;
            mwd   <= '0;
        end else begin
            busy  <= busy_next;
            done  <= done_next;
            err   <= err_next;
            rdata <= rdata_next;
            mwr   <= mwr_next;
            moe   <= moe_next;
            ma    <= ma_next;
            mwd   <= mwd_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_we    <= 1'b0;
            cap_sext  <= 1'b0;
            cap_size  <= 2'b00;
            cap_lane  <= 2'b00;
            cap_wdata <= '0;
        end else if (state == S_IDLE && req) begin
            cap_we    <= we;
            cap_sext  <= sext;
            cap_size  <= size;
            cap_lane  <= addr[1:0];
            cap_wdata <= wdata[15:0];
        end
    end

endmodule
